vram_port_arbiter: RTL and testbench
====================================

VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 10, BRAM word-address width; DATA_W, default 16, BRAM word width; STARVE_LIMIT, default 8, consecutive CPU denials before a forced grant.
REQ-002 Ports: clk, input, 1, single clock; reset, input, 1, asynchronous active-low reset.
REQ-003 Ports: vga_req, input, 1, scanout fetch request; vga_addr, input, ADDR_W, fetch address.
REQ-004 Ports: vga_rdata, output, DATA_W, fetched word; vga_rvalid, output, 1, vga_rdata valid this cycle.
REQ-005 Ports: cpu_req, input, 1; cpu_we, input, 1, 1=write; cpu_addr, input, ADDR_W; cpu_wdata, input, DATA_W.
REQ-006 Ports: cpu_gnt, output, 1, CPU access accepted this cycle; cpu_rdata, output, DATA_W; cpu_rvalid, output, 1.
REQ-007 Ports: addr_b, output, ADDR_W; data_b, output, DATA_W; we_b, output, 1; q_b, input, DATA_W; these connect to BRAM port B, which has 1-cycle registered read.
REQ-008 Ports: starved, output, 1, CPU denied on the previous cycle.

Function
REQ-009 Arbitration each cycle shall be combinational: vga_req wins; otherwise cpu_req is granted; cpu_gnt is high only in the cycle of acceptance.
REQ-010 An accepted request at edge E0 shall load addr_b, data_b and we_b at E0, then hold them until the next accepted request.
REQ-011 we_b shall be 1 for exactly one cycle per accepted CPU write, and 0 otherwise.
REQ-012 A 2-stage owner pipeline with tags NONE, VGA, CPU_RD shall track issued reads; a CPU write shall enter as NONE.
REQ-013 A read accepted at E0 shall return q_b in the cycle after E1: *_rvalid is high for that one cycle and *_rdata equals q_b.
REQ-014 Back-to-back reads shall be fully pipelined at one per cycle, with no bubbles.
REQ-015 *_rdata shall hold its last value when *_rvalid is low.
REQ-016 vga_rvalid and cpu_rvalid shall never both be high.
REQ-017 State machine: IDLE (no grant), VGA_ACC, CPU_ACC; the next state is the grant decision and state is registered.
REQ-018 Denial counter: increments when cpu_req=1 and cpu_gnt=0; clears on cpu_gnt or cpu_req=0; saturates at STARVE_LIMIT.
REQ-019 starved shall equal the registered value of (cpu_req & ~cpu_gnt).
REQ-020 A CPU write followed immediately by a read of the same address shall return the new data, because the BRAM port is single and ordered.
REQ-021 Withdrawal of cpu_req before grant is legal and shall leave no side effect.

Reset
REQ-022 When reset is low (asynchronous), all of the following shall be 0: addr_b, data_b, we_b, vga_rdata, vga_rvalid, cpu_rdata, cpu_rvalid, starved, the denial counter and the pipeline tags; state shall be IDLE.
REQ-023 Reads in flight when reset is asserted shall be discarded, and no rvalid shall be produced for them after release.
REQ-024 The first grant after reset release shall occur at the first rising edge with reset high.

Configuration
REQ-025 Macro VRAM_ARB_STARVE_GUARD_EN, when defined: the CPU is granted over vga_req in the cycle the denial counter equals STARVE_LIMIT; the VGA request is simply lost and is re-presented by its source.
REQ-026 Without VRAM_ARB_STARVE_GUARD_EN: strict VGA priority; the counter and starved output still operate, for observation only.

Structure
REQ-027 A shared package vram_arb_pkg shall hold the owner-tag and state enumerations plus default width constants.
REQ-028 Sub-module vram_rd_tag_pipe shall implement the 2-stage owner pipeline and the rvalid/rdata steering.

Verification
REQ-029 Scenario: idle, then a CPU read of 0x005 with BRAM[0x005]=0xBEEF -> cpu_gnt at E0, addr_b=0x005, cpu_rvalid=1 with cpu_rdata=0xBEEF in the cycle after E1.
REQ-030 Scenario: vga_req and cpu_req both high at 0x010/0x020 -> addr_b=0x010, cpu_gnt=0, starved=1 next cycle; the CPU is served the cycle after vga_req drops.
REQ-031 Scenario: CPU write 0x1234 to 0x03F, then a CPU read of 0x03F on the next cycle -> we_b pulses one cycle, and the read returns 0x1234.
REQ-032 Scenario: VGA reads 0x000..0x007 on consecutive cycles -> 8 consecutive vga_rvalid pulses with matching data, and no gaps.
REQ-033 Scenario (guard macro defined): vga_req held high and cpu_req held for 9 cycles -> CPU granted on the 9th cycle (counter=8), then the counter clears.
REQ-034 Scenario: reset asserted one cycle after a VGA read is issued -> no vga_rvalid ever appears for it, and all outputs read 0 while reset is low.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared types and default widths for the VRAM port arbiter
//
// Purpose: owner-tag and arbiter-state enumerations plus default width
// constants shared by vram_port_arbiter and vram_rd_tag_pipe.
// Ports: none (package).

package vram_arb_pkg;

  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_STARVE_LIMIT = 8;

  // Who owns the BRAM read data that is currently travelling down the pipe.
  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_VGA    = 2'd1,
    TAG_CPU_RD = 2'd2
  } owner_tag_e;

  // Registered grant decision: which requester owns BRAM port B this cycle.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_VGA_ACC = 2'd1,
    ST_CPU_ACC = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// rtl/vram_rd_tag_pipe.sv - 2-stage read owner pipeline with rvalid/rdata steering
//
// Purpose: follows each issued BRAM access for two edges so that the
// registered BRAM output q_b is steered to the requester that issued it.
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   issue_tag           - owner of the access being accepted this cycle
//   q_b                 - BRAM port B registered read data
//   vga_rdata/rvalid    - scanout read return (rdata holds when rvalid low)
//   cpu_rdata/rvalid    - CPU read return (rdata holds when rvalid low)

module vram_rd_tag_pipe
  import vram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  owner_tag_e        issue_tag,
  input  logic [DATA_W-1:0] q_b,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid
);

  owner_tag_e        tag1_q, tag1_d;
  owner_tag_e        tag2_q, tag2_d;
  logic [DATA_W-1:0] vga_hold_q, vga_hold_d;
  logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;

  // Stage 1 lines up with addr_b being presented to the BRAM; stage 2 lines
  // up with q_b carrying the word for that address.
  always_comb begin
    tag1_d     = issue_tag;
    tag2_d     = tag1_q;
    vga_rvalid = (tag2_q == TAG_VGA);
    cpu_rvalid = (tag2_q == TAG_CPU_RD);
    vga_hold_d = vga_rvalid ? q_b : vga_hold_q;
    cpu_hold_d = cpu_rvalid ? q_b : cpu_hold_q;
    // Pass q_b straight through in its valid cycle so no extra latency is
    // added on top of the BRAM's own output register.
    vga_rdata  = vga_rvalid ? q_b : vga_hold_q;
    cpu_rdata  = cpu_rvalid ? q_b : cpu_hold_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag1_q     <= TAG_NONE;
      tag2_q     <= TAG_NONE;
      vga_hold_q <= '0;
      cpu_hold_q <= '0;
    end else begin
      tag1_q     <= tag1_d;
      tag2_q     <= tag2_d;
      vga_hold_q <= vga_hold_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// rtl/vram_port_arbiter.sv - VGA/CPU arbiter for a single BRAM port B
//
// Purpose: shares one BRAM port between the scanout fetcher (priority) and
// the CPU, registers the port-B address/data/write strobe and returns read
// data to its owner through vram_rd_tag_pipe.
// Configuration: define VRAM_ARB_STARVE_GUARD_EN to force a CPU grant once
// the CPU has been denied STARVE_LIMIT consecutive cycles.
// Ports:
//   clk, reset                       - clock, asynchronous active-low reset
//   vga_req, vga_addr                - scanout fetch request
//   vga_rdata, vga_rvalid            - scanout fetch return
//   cpu_req, cpu_we, cpu_addr,
//   cpu_wdata                        - CPU access request
//   cpu_gnt                          - CPU access accepted this cycle
//   cpu_rdata, cpu_rvalid            - CPU read return
//   addr_b, data_b, we_b, q_b        - BRAM port B (1-cycle registered read)
//   starved                          - CPU was denied on the previous cycle

module vram_port_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] data_b,
  output logic              we_b,
  input  logic [DATA_W-1:0] q_b,
  output logic              starved
);

  localparam int                CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [DATA_W-1:0] data_b_q, data_b_d;
  logic              wr_q, wr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              starved_q, starved_d;
  logic              gnt_vga, gnt_cpu, denial;
  owner_tag_e        issue_tag;

  always_comb begin
    gnt_vga = vga_req;
    gnt_cpu = cpu_req & ~vga_req;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    // The VGA request losing here is simply dropped; its source re-presents it.
    if (cpu_req && (cnt_q == LIMIT)) begin
      gnt_vga = 1'b0;
      gnt_cpu = 1'b1;
    end
`endif

    state_d   = ST_IDLE;
    addr_b_d  = addr_b_q;
    data_b_d  = data_b_q;
    wr_d      = 1'b0;
    issue_tag = TAG_NONE;
    if (gnt_vga) begin
      state_d   = ST_VGA_ACC;
      addr_b_d  = vga_addr;
      issue_tag = TAG_VGA;
    end else if (gnt_cpu) begin
      state_d   = ST_CPU_ACC;
      addr_b_d  = cpu_addr;
      data_b_d  = cpu_wdata;
      wr_d      = cpu_we;
      // Writes produce no read data, so they travel down the pipe as NONE.
      issue_tag = cpu_we ? TAG_NONE : TAG_CPU_RD;
    end

    denial    = cpu_req & ~gnt_cpu;
    starved_d = denial;
    if (!denial) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_b_q  <= '0;
      data_b_q  <= '0;
      wr_q      <= 1'b0;
      cnt_q     <= '0;
      starved_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_b_q  <= addr_b_d;
      data_b_q  <= data_b_d;
      wr_q      <= wr_d;
      cnt_q     <= cnt_d;
      starved_q <= starved_d;
    end
  end

  assign cpu_gnt = gnt_cpu;
  assign addr_b  = addr_b_q;
  assign data_b  = data_b_q;
  // CPU_ACC lasts exactly one cycle per accepted access, so the strobe
  // cannot stretch across back-to-back writes.
  assign we_b    = (state_q == ST_CPU_ACC) & wr_q;
  assign starved = starved_q;

  vram_rd_tag_pipe #(
    .DATA_W(DATA_W)
  ) u_tag_pipe (
    .clk       (clk),
    .reset     (reset),
    .issue_tag (issue_tag),
    .q_b       (q_b),
    .vga_rdata (vga_rdata),
    .vga_rvalid(vga_rvalid),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid)
  );

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb/tb_vram_port_arbiter.sv - directed self-checking bench for vram_port_arbiter

module tb_vram_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_rdata;
  logic              vga_rvalid;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] data_b;
  logic              we_b;
  logic [DATA_W-1:0] q_b;
  logic              starved;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] vga_exp [0:7];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // BRAM port B: read-first, one-cycle registered read.
  always @(posedge clk) begin
    if (we_b) mem[addr_b] <= data_b;
    q_b <= mem[addr_b];
  end

  vram_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vga_req   (vga_req),
    .vga_addr  (vga_addr),
    .vga_rdata (vga_rdata),
    .vga_rvalid(vga_rvalid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_gnt   (cpu_gnt),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .addr_b    (addr_b),
    .data_b    (data_b),
    .we_b      (we_b),
    .q_b       (q_b),
    .starved   (starved)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr_b"},     32'(addr_b),     32'h0);
    chk({tag, "_data_b"},     32'(data_b),     32'h0);
    chk({tag, "_we_b"},       32'(we_b),       32'h0);
    chk({tag, "_vga_rdata"},  32'(vga_rdata),  32'h0);
    chk({tag, "_vga_rvalid"}, 32'(vga_rvalid), 32'h0);
    chk({tag, "_cpu_rdata"},  32'(cpu_rdata),  32'h0);
    chk({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'h0);
    chk({tag, "_starved"},    32'(starved),    32'h0);
  endtask

  initial begin
    reset     = 1'b0;
    vga_req   = 1'b0;
    vga_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) mem[i] = 16'hA000 + 16'(i);
    mem[10'h005] = 16'hBEEF;
    mem[10'h010] = 16'h1111;
    mem[10'h020] = 16'h2222;
    vga_exp = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
                16'hA004, 16'hBEEF, 16'hA006, 16'hA007};

    // Reset state
    step();
    step();
    chk_all_zero("rst");
    chk("rst_cpu_gnt", 32'(cpu_gnt), 32'h0);

    // CPU read of 0x005 right at reset release
    reset    = 1'b1;
    cpu_req  = 1'b1;
    cpu_addr = 10'h005;
    #1;
    chk("rd_gnt", 32'(cpu_gnt), 32'h1);
    step();
    chk("rd_addr_b", 32'(addr_b), 32'h005);
    chk("rd_we_b", 32'(we_b), 32'h0);
    chk("rd_early_rvalid", 32'(cpu_rvalid), 32'h0);
    cpu_req = 1'b0;
    step();
    chk("rd_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("rd_rdata", 32'(cpu_rdata), 32'hBEEF);
    chk("rd_vga_rvalid", 32'(vga_rvalid), 32'h0);
    step();
    chk("rd_rvalid_off", 32'(cpu_rvalid), 32'h0);
    chk("rd_rdata_hold", 32'(cpu_rdata), 32'hBEEF);

    // VGA beats CPU; CPU served the cycle after vga_req drops
    vga_req  = 1'b1;
    vga_addr = 10'h010;
    cpu_req  = 1'b1;
    cpu_addr = 10'h020;
    #1;
    chk("pri_gnt_denied", 32'(cpu_gnt), 32'h0);
    step();
    chk("pri_addr_b_vga", 32'(addr_b), 32'h010);
    chk("pri_starved", 32'(starved), 32'h1);
    vga_req = 1'b0;
    #1;
    chk("pri_gnt_after", 32'(cpu_gnt), 32'h1);
    step();
    chk("pri_addr_b_cpu", 32'(addr_b), 32'h020);
    chk("pri_starved_clr", 32'(starved), 32'h0);
    chk("pri_vga_rvalid", 32'(vga_rvalid), 32'h1);
    chk("pri_vga_rdata", 32'(vga_rdata), 32'h1111);
    cpu_req = 1'b0;
    step();
    chk("pri_cpu_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("pri_cpu_rdata", 32'(cpu_rdata), 32'h2222);
    chk("pri_vga_rvalid_off", 32'(vga_rvalid), 32'h0);
    step();

    // CPU write then immediate read of the same address
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 10'h03F;
    cpu_wdata = 16'h1234;
    #1;
    chk("wr_gnt", 32'(cpu_gnt), 32'h1);
    step();
    chk("wr_we_b", 32'(we_b), 32'h1);
    chk("wr_addr_b", 32'(addr_b), 32'h03F);
    chk("wr_data_b", 32'(data_b), 32'h1234);
    cpu_we = 1'b0;
    step();
    chk("wr_we_b_pulse", 32'(we_b), 32'h0);
    chk("wr_no_rvalid", 32'(cpu_rvalid), 32'h0);
    cpu_req = 1'b0;
    step();
    chk("wr_rd_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("wr_rd_rdata", 32'(cpu_rdata), 32'h1234);
    step();

    // Back-to-back VGA reads 0x000..0x007
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        vga_req  = 1'b1;
        vga_addr = ADDR_W'(k);
      end else begin
        vga_req = 1'b0;
      end
      step();
      chk($sformatf("burst_rvalid_%0d", k), 32'(vga_rvalid), 32'((k >= 1) && (k <= 8)));
      chk($sformatf("burst_cpu_rvalid_%0d", k), 32'(cpu_rvalid), 32'h0);
      if ((k >= 1) && (k <= 8))
        chk($sformatf("burst_rdata_%0d", k - 1), 32'(vga_rdata), 32'(vga_exp[k-1]));
    end

    // Starvation: VGA and CPU held together for 10 cycles
    for (int k = 1; k <= 10; k++) begin
      vga_req  = 1'b1;
      vga_addr = 10'h000;
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 10'h020;
      #1;
      chk($sformatf("stv_gnt_%0d", k), 32'(cpu_gnt), 32'(GUARD && (k == 9)));
      step();
      if (k == 1) chk("stv_starved_1", 32'(starved), 32'h1);
      if (k == 9) begin
        chk("stv_starved_9", 32'(starved), 32'(!GUARD));
        chk("stv_addr_b_9", 32'(addr_b), GUARD ? 32'h020 : 32'h000);
      end
      if (k == 10) begin
        chk("stv_starved_10", 32'(starved), 32'h1);
        chk("stv_cpu_rvalid", 32'(cpu_rvalid), 32'(GUARD));
        chk("stv_cpu_rdata", 32'(cpu_rdata), GUARD ? 32'h2222 : 32'h1234);
        chk("stv_vga_rvalid", 32'(vga_rvalid), 32'(!GUARD));
      end
    end
    vga_req = 1'b0;
    cpu_req = 1'b0;
    step();
    step();
    step();

    // Withdrawn CPU write leaves memory untouched
    vga_req   = 1'b1;
    vga_addr  = 10'h001;
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 10'h03F;
    cpu_wdata = 16'hDEAD;
    step();
    chk("wd_we_b", 32'(we_b), 32'h0);
    vga_req = 1'b0;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    step();
    chk("wd_we_b_2", 32'(we_b), 32'h0);
    cpu_req = 1'b1;
    step();
    cpu_req = 1'b0;
    step();
    chk("wd_rvalid", 32'(cpu_rvalid), 32'h1);
    chk("wd_rdata", 32'(cpu_rdata), 32'h1234);
    step();

    // Reset while a VGA read is in flight
    vga_req  = 1'b1;
    vga_addr = 10'h002;
    step();
    vga_req = 1'b0;
    reset   = 1'b0;
    #1;
    chk_all_zero("rif");
    step();
    chk("rif_rvalid_in_rst", 32'(vga_rvalid), 32'h0);
    reset = 1'b1;
    step();
    chk("rif_rvalid_rel1", 32'(vga_rvalid), 32'h0);
    step();
    chk("rif_rvalid_rel2", 32'(vga_rvalid), 32'h0);
    chk("rif_rdata_rel2", 32'(vga_rdata), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
